// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  // addi x0, x0, 0 : the canonical RISC-V NOP loaded by flush/bubble controls
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hazard_state_t;

  // A load in EX feeds the instruction in ID; x0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] ex_rd,
    input logic [REG_W-1:0] id_rs1,
    input logic [REG_W-1:0] id_rs2
  );
    return mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that outranks increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / mul-div occupancy sequencer with a stall-cycle counter.
// Controls are combinational from state and inputs so a stall acts in the cycle of its cause.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_md,
  input  logic             EX_branch_taken,
  input  logic             md_done,
  input  logic             stall_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_bubble,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_cycles,
  output hazard_state_t    dbg_state
);

  hazard_state_t state_q;
  hazard_state_t state_d;
  logic          load_use;

  assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2);

  // Mul/div handshake: md_start is a one-cycle request issued from RUN; the unit
  // answers with a one-cycle md_done, on which the result enters EX/MEM and EX frees.
  always_comb begin
    state_d       = state_q;
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    md_start      = 1'b0;
    if (!rst_n) begin
      state_d     = RUN;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_write = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (EX_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (ID_EX_md) begin
            md_start      = 1'b1;
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
            state_d       = MD_WAIT;
          end else if (load_use) begin
            // One cycle is enough: the load advances to MEM and forwarding covers the rest.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state_d = RUN;
          end else begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rst_n && !PC_write),
    .clr  (stall_clr),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change 1 ns after posedge, outputs sampled at negedge.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] IF_ID_rs1;
  logic [REG_W-1:0] IF_ID_rs2;
  logic [REG_W-1:0] ID_EX_rd;
  logic             ID_EX_MemRead;
  logic             ID_EX_md;
  logic             EX_branch_taken;
  logic             md_done;
  logic             stall_clr;
  logic             PC_write;
  logic             IF_ID_write;
  logic             ID_EX_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             EX_MEM_bubble;
  logic             md_start;
  logic [CNT_W-1:0] stall_cycles;
  hazard_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(
    .CNT_W(CNT_W),
    .REG_W(REG_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_md       (ID_EX_md),
    .EX_branch_taken(EX_branch_taken),
    .md_done        (md_done),
    .stall_clr      (stall_clr),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .ID_EX_write    (ID_EX_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .EX_MEM_bubble  (EX_MEM_bubble),
    .md_start       (md_start),
    .stall_cycles   (stall_cycles),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch and mul/div must never be in EX together.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      assert (!(EX_branch_taken && ID_EX_md))
      else begin
        n_fail++;
        $error("FAIL illegal_branch_md observed=1 expected=0");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_bubble, EX_MEM_bubble, md_start}
  task automatic check_ctrl(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, 32'({PC_write, IF_ID_write, ID_EX_write, IF_ID_flush,
                    ID_EX_bubble, EX_MEM_bubble, md_start}), 32'(exp));
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IF_ID_rs1       = '0;
    IF_ID_rs2       = '0;
    ID_EX_rd        = '0;
    ID_EX_MemRead   = 1'b0;
    ID_EX_md        = 1'b0;
    EX_branch_taken = 1'b0;
    md_done         = 1'b0;
    stall_clr       = 1'b0;
  endtask

  task automatic drive_load(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                            input logic [REG_W-1:0] rs2);
    ID_EX_MemRead = 1'b1;
    ID_EX_rd      = rd;
    IF_ID_rs1     = rs1;
    IF_ID_rs2     = rs2;
  endtask

  localparam logic [6:0] C_RUN    = 7'b111_0000;
  localparam logic [6:0] C_RESET  = 7'b000_0000;
  localparam logic [6:0] C_LDUSE  = 7'b001_0100;
  localparam logic [6:0] C_FLUSH  = 7'b111_1100;
  localparam logic [6:0] C_MDSTRT = 7'b000_0011;
  localparam logic [6:0] C_MDWAIT = 7'b000_0010;

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset: outputs forced low even with a mul/div presented
    #2;
    ID_EX_md = 1'b1;
    check_ctrl("reset_ctrl", C_RESET);
    check("reset_cnt", 32'(stall_cycles), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(RUN));
    next_cycle();
    ID_EX_md = 1'b0;
    rst_n    = 1'b1;
    check_ctrl("idle_ctrl", C_RUN);
    next_cycle();

    // Load-use: lw x5 in EX, rs2=x5 in ID
    drive_load(5'd5, 5'd3, 5'd5);
    check_ctrl("lduse_stall", C_LDUSE);
    next_cycle();
    ID_EX_MemRead = 1'b0;
    check_ctrl("lduse_release", C_RUN);
    check("lduse_cnt", 32'(stall_cycles), 32'd1);
    next_cycle();

    // Load to x0 never stalls
    drive_load(5'd0, 5'd0, 5'd4);
    check_ctrl("x0_load", C_RUN);
    next_cycle();
    check("x0_cnt", 32'(stall_cycles), 32'd1);

    // Taken branch wins over a simultaneous load-use match
    drive_load(5'd7, 5'd7, 5'd2);
    EX_branch_taken = 1'b1;
    check_ctrl("branch_flush", C_FLUSH);
    next_cycle();
    idle_inputs();
    check("branch_cnt", 32'(stall_cycles), 32'd1);

    // Mul/div: done arrives 4 cycles after start
    ID_EX_md = 1'b1;
    check_ctrl("md_start", C_MDSTRT);
    next_cycle();
    check("md_state_wait", 32'(dbg_state), 32'(MD_WAIT));
    check_ctrl("md_wait1", C_MDWAIT);
    next_cycle();
    drive_load(5'd6, 5'd6, 5'd6);
    EX_branch_taken = 1'b1;
    ID_EX_md        = 1'b0;
    check_ctrl("md_wait2_ignore", C_MDWAIT);
    next_cycle();
    idle_inputs();
    ID_EX_md = 1'b1;
    check_ctrl("md_wait3", C_MDWAIT);
    next_cycle();
    md_done = 1'b1;
    check_ctrl("md_done", C_RUN);
    next_cycle();
    idle_inputs();
    check("md_state_run", 32'(dbg_state), 32'(RUN));
    check("md_cnt", 32'(stall_cycles), 32'd5);

    // Stray md_done in RUN has no effect
    md_done = 1'b1;
    check_ctrl("stray_done", C_RUN);
    next_cycle();
    md_done = 1'b0;
    check("stray_state", 32'(dbg_state), 32'(RUN));

    // Reset two cycles after md_start
    ID_EX_md = 1'b1;
    next_cycle();
    next_cycle();
    check("pre_reset_state", 32'(dbg_state), 32'(MD_WAIT));
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 32'(RUN));
    check_ctrl("midrst_ctrl", C_RESET);
    check("midrst_cnt", 32'(stall_cycles), 32'd0);
    next_cycle();
    ID_EX_md = 1'b0;
    rst_n    = 1'b1;
    check_ctrl("postrst_ctrl", C_RUN);
    check("postrst_state", 32'(dbg_state), 32'(RUN));
    next_cycle();

    // Saturation at 4 bits after 20 load-use stalls
    drive_load(5'd9, 5'd9, 5'd1);
    for (int i = 0; i < 20; i++) next_cycle();
    check("sat_cnt", 32'(stall_cycles), 32'd15);
    stall_clr = 1'b1;
    check_ctrl("clr_stall_ctrl", C_LDUSE);
    next_cycle();
    stall_clr = 1'b0;
    check("clr_cnt", 32'(stall_cycles), 32'd0);
    next_cycle();
    check("after_clr_cnt", 32'(stall_cycles), 32'd1);
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
